axis_uart_rx: RTL and testbench

Standalone UART receiver that deserialises the `uart_rx` line into bytes presented on an AXI-Stream master port. It is the receive-side counterpart to the team's UART transmit path. It is instantiated beside the transmitter wherever only the inbound direction is needed, for example in loopback benches and RX-only debug ports. It provides mid-bit sampling, optional parity checking, framing checks and a one-entry output holding register.

---
 rtl/axis_uart_rx.sv | 113 +++++++++++
 tb/tb_axis_uart_rx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_uart_rx.sv
// axis_uart_rx: UART receiver presenting bytes on an AXI-Stream master with parity/framing checks.
// Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 sampling of every bit.
module axis_uart_rx #(
  parameter int AXI_DATA_WIDTH = 8,
  parameter int CLOCK = 100_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int PARITY_BITS = 0
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      uart_rx,
  output logic                      rx_done,
  output logic [1:0]                rx_error,
  output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready
);
  localparam int CPB = CLOCK / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW = $clog2(CPB);
  localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_END = CW'(CPB - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state;
  logic [1:0] sync_ff;
  logic sync_d;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic par_err, frm_err;
  logic bit_val, frm_now, good;
`ifdef UART_RX_MAJORITY_VOTE_EN
  logic sync_dd;
  assign bit_val = (sync_ff[1] & sync_d) | (sync_ff[1] & sync_dd) | (sync_d & sync_dd);
`else
  assign bit_val = sync_ff[1];
`endif
  assign frm_now = frm_err | ~bit_val;
  assign good = ~frm_now & ~par_err;
  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
      sync_ff <= 2'b11;
      sync_d <= 1'b1;
`ifdef UART_RX_MAJORITY_VOTE_EN
      sync_dd <= 1'b1;
`endif
      cnt <= '0;
      idx <= '0;
      stop_idx <= 1'b0;
      shreg <= '0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
      rx_done <= 1'b0;
      rx_error <= 2'b00;
      m_axis_tdata <= '0;
      m_axis_tvalid <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], uart_rx};
      sync_d <= sync_ff[1];
`ifdef UART_RX_MAJORITY_VOTE_EN
      sync_dd <= sync_d;
`endif
      rx_done <= 1'b0;
      if (m_axis_tready) m_axis_tvalid <= 1'b0;
      cnt <= cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (sync_d & ~sync_ff[1]) state <= START;
        end
        START: if (cnt == HALF_END) begin
          cnt <= '0;
          idx <= '0;
          stop_idx <= 1'b0;
          par_err <= 1'b0;
          frm_err <= 1'b0;
          state <= bit_val ? IDLE : DATA;
        end
        DATA: if (cnt == BIT_END) begin
          cnt <= '0;
          shreg <= {bit_val, shreg[DATA_BITS-1:1]};
          idx <= idx + 1'b1;
          if (idx == 3'(DATA_BITS - 1)) state <= (PARITY_BITS != 0) ? PARITY : STOP;
        end
        PARITY: if (cnt == BIT_END) begin
          cnt <= '0;
          par_err <= ((^shreg) ^ bit_val) != (PARITY_BITS == 1);
          state <= STOP;
        end
        STOP: if (cnt == BIT_END) begin
          cnt <= '0;
          frm_err <= frm_now;
          stop_idx <= 1'b1;
          if (stop_idx == 1'(STOP_BITS - 1)) begin
            state <= IDLE;
            rx_done <= 1'b1;
            rx_error <= {frm_now, par_err};
            // a full, stalled holding register keeps its byte; the new one is lost
            if (good && (!m_axis_tvalid || m_axis_tready)) begin
              m_axis_tdata <= AXI_DATA_WIDTH'(shreg);
              m_axis_tvalid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_uart_rx.sv
// tb_axis_uart_rx: scoreboard bench for two receiver configurations (8E1 and 7N2).
module tb_axis_uart_rx;
  localparam int CLK_HZ = 3_200_000;
  localparam int BAUD = 100_000;
  localparam int CPB = CLK_HZ / BAUD;
  logic clk = 1'b0;
  logic areset = 1'b1;
  logic line [2];
  logic rdy [2];
  logic rnd_bit [2];
  logic rdy_eff [2];
  logic rnd_rdy = 1'b0;
  logic done [2];
  logic valid [2];
  logic [1:0] err [2];
  logic [7:0] dat [2];
  logic stall [2];
  logic [7:0] held [2];
  int nbits [2] = '{8, 7};
  int nstop [2] = '{1, 2};
  int pmode [2] = '{2, 0};
  int done_cnt [2] = '{0, 0};
  int exp_done [2] = '{0, 0};
  logic [1:0] last_err [2];
  logic [1:0] eq_err0 [$];
  logic [1:0] eq_err1 [$];
  logic [7:0] eq_dat0 [$];
  logic [7:0] eq_dat1 [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign rdy_eff[0] = rnd_rdy ? rnd_bit[0] : rdy[0];
  assign rdy_eff[1] = rnd_rdy ? rnd_bit[1] : rdy[1];

  axis_uart_rx #(.AXI_DATA_WIDTH(8), .CLOCK(CLK_HZ), .BAUD_RATE(BAUD),
    .DATA_BITS(8), .STOP_BITS(1), .PARITY_BITS(2)) dut_a (
    .aclk(clk), .areset(areset), .uart_rx(line[0]), .rx_done(done[0]),
    .rx_error(err[0]), .m_axis_tdata(dat[0]), .m_axis_tvalid(valid[0]),
    .m_axis_tready(rdy_eff[0]));
  axis_uart_rx #(.AXI_DATA_WIDTH(8), .CLOCK(CLK_HZ), .BAUD_RATE(BAUD),
    .DATA_BITS(7), .STOP_BITS(2), .PARITY_BITS(0)) dut_b (
    .aclk(clk), .areset(areset), .uart_rx(line[1]), .rx_done(done[1]),
    .rx_error(err[1]), .m_axis_tdata(dat[1]), .m_axis_tvalid(valid[1]),
    .m_axis_tready(rdy_eff[1]));

  function automatic void push_err(int i, logic [1:0] e);
    if (i == 0) eq_err0.push_back(e); else eq_err1.push_back(e);
  endfunction
  function automatic void push_dat(int i, logic [7:0] d);
    if (i == 0) eq_dat0.push_back(d); else eq_dat1.push_back(d);
  endfunction
  function automatic logic [1:0] pop_err(int i);
    if (i == 0) return eq_err0.pop_front();
    return eq_err1.pop_front();
  endfunction
  function automatic logic [7:0] pop_dat(int i);
    if (i == 0) return eq_dat0.pop_front();
    return eq_dat1.pop_front();
  endfunction
  function automatic int nerr(int i);
    return (i == 0) ? eq_err0.size() : eq_err1.size();
  endfunction
  function automatic int ndat(int i);
    return (i == 0) ? eq_dat0.size() : eq_dat1.size();
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive(int i, logic v, int n);
    line[i] = v;
    idle(n);
  endtask

  // Reference: build the frame from the line rules and predict the outcome.
  task automatic send(int i, logic [7:0] d, bit bad_par, bit bad_stop, int spike = -1);
    logic [7:0] m;
    logic [1:0] e;
    logic p;
    m = d & 8'((1 << nbits[i]) - 1);
    e = {bad_stop, bad_par && pmode[i] != 0};
    push_err(i, e);
    last_err[i] = e;
    exp_done[i]++;
    if (e == 2'b00 && (ndat(i) == 0 || rdy[i])) push_dat(i, m);
    drive(i, 1'b0, CPB);
    for (int k = 0; k < nbits[i]; k++) begin
      if (k == spike) begin
        drive(i, m[k], 17);
        drive(i, ~m[k], 1);
        drive(i, m[k], CPB - 18);
      end else drive(i, m[k], CPB);
    end
    if (pmode[i] != 0) begin
      p = (^m) ^ (pmode[i] == 1) ^ bad_par;
      drive(i, p, CPB);
    end
    for (int k = 0; k < nstop[i]; k++) drive(i, ~bad_stop, CPB);
  endtask

  task automatic drain(int i);
    int t = 0;
    while (ndat(i) != 0 && t < 300) begin idle(1); t++; end
    checks++;
    if (ndat(i) != 0) begin
      errors++;
      $display("FAIL drain%0d: actual=%0d beats pending required=0", i, ndat(i));
      if (i == 0) eq_dat0.delete(); else eq_dat1.delete();
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (stall[i] === 1'b1) begin
        check($sformatf("hold_valid%0d", i), int'(valid[i]), 1);
        check($sformatf("hold_data%0d", i), int'(dat[i]), int'(held[i]));
      end
      stall[i] <= valid[i] & ~rdy_eff[i];
      held[i] <= dat[i];
      if (done[i]) begin
        done_cnt[i] <= done_cnt[i] + 1;
        if (nerr(i) == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done%0d: actual rx_error=%0b required no frame", i, err[i]);
        end else check($sformatf("rx_error%0d", i), int'(err[i]), int'(pop_err(i)));
      end
      if (valid[i] && rdy_eff[i]) begin
        if (ndat(i) == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat%0d: actual tdata=%0h required no beat", i, dat[i]);
        end else check($sformatf("tdata%0d", i), int'(dat[i]), int'(pop_dat(i)));
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    rnd_bit[0] = 1'($urandom);
    rnd_bit[1] = 1'($urandom);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m;
    int i, gap;
    line[0] = 1'b1; line[1] = 1'b1;
    rdy[0] = 1'b0; rdy[1] = 1'b0;
    stall[0] = 1'b0; stall[1] = 1'b0;
    last_err[0] = 2'b00; last_err[1] = 2'b00;
    idle(4);
    areset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_done%0d", k), int'(done[k]), 0);
      check($sformatf("rst_error%0d", k), int'(err[k]), 0);
      check($sformatf("rst_valid%0d", k), int'(valid[k]), 0);
      check($sformatf("rst_data%0d", k), int'(dat[k]), 0);
    end
    @(posedge clk); #1;
    send(0, 8'hA5, 0, 0);
    idle(40);
    check("a5_held_valid", int'(valid[0]), 1);
    rdy[0] = 1'b1;
    idle(10);
    check("a5_consumed", int'(valid[0]), 0);
    send(0, 8'h0F, 1, 0);
    idle(CPB);
    check("parity_no_valid", int'(valid[0]), 0);
    send(0, 8'h3C, 0, 1);
    idle(40 * CPB);
    check("low_line_done_count", done_cnt[0], exp_done[0]);
    check("framing_no_valid", int'(valid[0]), 0);
    line[0] = 1'b1;
    idle(CPB);
    send(0, 8'h3C, 0, 0);
    idle(20);
    rdy[0] = 1'b0;
    send(0, 8'h11, 0, 0);
    send(0, 8'h22, 0, 0);
    idle(20);
    check("overrun_done_count", done_cnt[0], exp_done[0]);
    check("overrun_valid", int'(valid[0]), 1);
    rdy[0] = 1'b1;
    idle(20);
    for (int k = 0; k < 2; k++) begin
      drive(k, 1'b0, 8);
      drive(k, 1'b1, 3 * CPB);
      check($sformatf("glitch_done_count%0d", k), done_cnt[k], exp_done[k]);
      check($sformatf("glitch_error%0d", k), int'(err[k]), int'(last_err[k]));
    end
    m = 8'h5A;
    drive(0, 1'b0, CPB);
    for (int k = 0; k < 4; k++) drive(0, m[k], CPB);
    drive(0, m[4], CPB / 2);
    areset = 1'b1;
    idle(2);
    areset = 1'b0;
    line[0] = 1'b1;
    last_err[0] = 2'b00; last_err[1] = 2'b00;
    idle(2 * CPB);
    check("midreset_error", int'(err[0]), int'(last_err[0]));
    check("midreset_done_count", done_cnt[0], exp_done[0]);
    send(0, 8'hC3, 0, 0);
    idle(CPB);
    rdy[1] = 1'b1;
    send(1, 8'h7F, 0, 0);
    send(1, 8'hFF, 0, 0);
    send(1, 8'h55, 0, 1);
    line[1] = 1'b1;
    idle(CPB);
    send(1, 8'h2A, 1, 0);
    idle(CPB);
    rnd_rdy = 1'b1;
    for (int n = 0; n < 24; n++) begin
      i = int'($urandom_range(0, 1));
      m = 8'($urandom);
      drain(i);
      send(i, m, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
      if (line[i] == 1'b0) begin line[i] = 1'b1; idle(CPB); end
      gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 40));
      idle(gap);
    end
`ifdef UART_RX_MAJORITY_VOTE_EN
    rnd_rdy = 1'b0;
    rdy[0] = 1'b1;
    drain(0);
    send(0, 8'h00, 0, 0, 3);
`endif
    rnd_rdy = 1'b0;
    rdy[0] = 1'b1; rdy[1] = 1'b1;
    idle(50);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("end_done_count%0d", k), done_cnt[k], exp_done[k]);
      check($sformatf("end_pending_err%0d", k), nerr(k), 0);
      check($sformatf("end_pending_data%0d", k), ndat(k), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
